// File: rtl/boulder_scroller.sv
// Frame-level obstacle sequencer: moves/respawns two boulders per frame tick and
// runs the go/cd_done handshake with the collision checker. Optional macro: BOULDER_LFSR_EN.
module boulder_scroller #(
  parameter int unsigned X_START   = 159,
  parameter int unsigned SPEED     = 1,
  parameter int unsigned B1_OFFSET = 80,
  parameter int unsigned Y_LANE0   = 100,
  parameter int unsigned Y_LANE1   = 60,
  parameter logic [2:0]  COLOUR0   = 3'b110,
  parameter logic [2:0]  COLOUR1   = 3'b101
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        frame_tick,
  input  logic        cd_done,
  input  logic        gg,
  output logic [17:0] boulder_0,
  output logic [17:0] boulder_1,
  output logic        go,
  output logic        frame_done,
  output logic        halted,
  output logic        overrun
);

  localparam logic [7:0] X_START_B = 8'(X_START);
  localparam logic [7:0] SPEED_B   = 8'(SPEED);
  localparam logic [7:0] X1_INIT   = 8'(X_START - B1_OFFSET);
  localparam logic [6:0] Y0_INIT   = 7'(Y_LANE0);
  localparam logic [6:0] Y1_INIT   = 7'(Y_LANE1);

  typedef enum logic [2:0] {IDLE, MOVE, LAUNCH, WAIT_CD, DONE, HALT} state_t;

  state_t     state;
  logic [7:0] x0, x1;
  logic [6:0] y0, y1;
  logic [6:0] respawn_y0, respawn_y1;

`ifdef BOULDER_LFSR_EN
  logic [7:0] lfsr;

  function automatic logic [6:0] clamp_y(input logic [6:0] r);
    return (r >= 7'd120) ? r - 7'd8 : r;
  endfunction

  assign respawn_y0 = clamp_y(lfsr[6:0]);
  assign respawn_y1 = clamp_y(~lfsr[6:0]);

  // Fibonacci form, x^8+x^6+x^5+x^4+1; frozen together with the playfield in HALT
  always_ff @(posedge clock) begin
    if (!resetn)
      lfsr <= 8'hA5;
    else if (state != HALT)
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
`else
  assign respawn_y0 = Y0_INIT;
  assign respawn_y1 = Y1_INIT;
`endif

  assign boulder_0 = {x0, y0, COLOUR0};
  assign boulder_1 = {x1, y1, COLOUR1};

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= IDLE;
      x0         <= X_START_B;
      y0         <= Y0_INIT;
      x1         <= X1_INIT;
      y1         <= Y1_INIT;
      go         <= 1'b0;
      frame_done <= 1'b0;
      halted     <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      go         <= 1'b0;
      frame_done <= 1'b0;

      if (state == MOVE) begin
        if (x0 >= SPEED_B) begin
          x0 <= x0 - SPEED_B;
        end else begin
          x0 <= X_START_B;
          y0 <= respawn_y0;
        end
        if (x1 >= SPEED_B) begin
          x1 <= x1 - SPEED_B;
        end else begin
          x1 <= X_START_B;
          y1 <= respawn_y1;
        end
      end

      if (frame_tick && state != IDLE && state != HALT)
        overrun <= 1'b1;

      // gg wins over every other transition, including a coincident cd_done
      if (gg) begin
        state  <= HALT;
        halted <= 1'b1;
      end else begin
        case (state)
          IDLE:    if (frame_tick) state <= MOVE;
          MOVE: begin
            state <= LAUNCH;
            go    <= 1'b1;
          end
          LAUNCH:  state <= WAIT_CD;
          WAIT_CD: if (cd_done) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
          DONE:    state <= IDLE;
          HALT:    state <= HALT;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_boulder_scroller.sv
// Randomised bench for boulder_scroller: two instances (SPEED=1 and SPEED=4) share
// stimulus and are checked every cycle against a frame-level reference model.
module tb_boulder_scroller;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        frame_tick = 1'b0;
  logic        cd_done = 1'b0;
  logic        gg = 1'b0;
  logic [17:0] b0 [2];
  logic [17:0] b1 [2];
  logic        go [2];
  logic        fd [2];
  logic        hl [2];
  logic        ov [2];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  boulder_scroller #(.SPEED(1)) dut_a (
    .clock(clock), .resetn(resetn), .frame_tick(frame_tick), .cd_done(cd_done), .gg(gg),
    .boulder_0(b0[0]), .boulder_1(b1[0]), .go(go[0]), .frame_done(fd[0]),
    .halted(hl[0]), .overrun(ov[0]));

  boulder_scroller #(.SPEED(4)) dut_b (
    .clock(clock), .resetn(resetn), .frame_tick(frame_tick), .cd_done(cd_done), .gg(gg),
    .boulder_0(b0[1]), .boulder_1(b1[1]), .go(go[1]), .frame_done(fd[1]),
    .halted(hl[1]), .overrun(ov[1]));

  // Reference model: phase 0 idle, 1 move, 2 launch, 3 waiting, 4 done, 5 halted
  int         sp [2] = '{1, 4};
  int         ph [2];
  int         mx0 [2], my0 [2], mx1 [2], my1 [2];
  bit         mgo [2], mfd [2], mhalt [2], movr [2];
  bit         rsp0 [2], rsp1 [2];
  logic [7:0] mlfsr [2];

  function automatic int respawn_y(input logic [7:0] l, input int which);
    int r;
`ifdef BOULDER_LFSR_EN
    r = (which == 0) ? int'(l[6:0]) : 127 - int'(l[6:0]);
    if (r >= 120) r = r - 8;
`else
    r = (which == 0) ? 100 : 60;
`endif
    return r;
  endfunction

  task automatic step_model(input int i);
    logic [7:0] l;
    l = mlfsr[i];
    rsp0[i] = 0;
    rsp1[i] = 0;
    if (!resetn) begin
      ph[i] = 0; mx0[i] = 159; my0[i] = 100; mx1[i] = 79; my1[i] = 60;
      mgo[i] = 0; mfd[i] = 0; mhalt[i] = 0; movr[i] = 0; mlfsr[i] = 8'hA5;
      return;
    end
    mgo[i] = 0;
    mfd[i] = 0;
    if (ph[i] == 1) begin
      if (mx0[i] >= sp[i]) mx0[i] -= sp[i];
      else begin mx0[i] = 159; my0[i] = respawn_y(l, 0); rsp0[i] = 1; end
      if (mx1[i] >= sp[i]) mx1[i] -= sp[i];
      else begin mx1[i] = 159; my1[i] = respawn_y(l, 1); rsp1[i] = 1; end
    end
    if (frame_tick && ph[i] != 0 && ph[i] != 5) movr[i] = 1;
    if (ph[i] != 5) mlfsr[i] = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    if (gg) begin
      ph[i] = 5;
      mhalt[i] = 1;
    end else begin
      case (ph[i])
        0: if (frame_tick) ph[i] = 1;
        1: begin ph[i] = 2; mgo[i] = 1; end
        2: ph[i] = 3;
        3: if (cd_done) begin ph[i] = 4; mfd[i] = 1; end
        4: ph[i] = 0;
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string name, input int i, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40)
        $display("FAIL %s dut%0d t=%0t: got %h expected %h", name, i, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      chk("boulder_0", i, b0[i], 18'(mx0[i] * 1024 + my0[i] * 8 + 6));
      chk("boulder_1", i, b1[i], 18'(mx1[i] * 1024 + my1[i] * 8 + 5));
      chk("go", i, 18'(go[i]), 18'(mgo[i]));
      chk("frame_done", i, 18'(fd[i]), 18'(mfd[i]));
      chk("halted", i, 18'(hl[i]), 18'(mhalt[i]));
      chk("overrun", i, 18'(ov[i]), 18'(movr[i]));
      if (rsp0[i] || rsp1[i]) begin
        logic [17:0] w;
        w = rsp0[i] ? b0[i] : b1[i];
        chk("respawn_x", i, 18'(w[17:10]), 18'd159);
        chk("respawn_colour", i, 18'(w[2:0]), rsp0[i] ? 18'd6 : 18'd5);
`ifdef BOULDER_LFSR_EN
        chk("respawn_y_range", i, 18'(w[9:3] < 7'd120), 18'd1);
`else
        chk("respawn_y_lane", i, 18'(w[9:3]), rsp0[i] ? 18'd100 : 18'd60);
`endif
      end
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    for (int i = 0; i < 2; i++) step_model(i);
    #1;
    compare_all();
  endtask

  task automatic check_reset_values();
    for (int i = 0; i < 2; i++) begin
      chk("rst_b0", i, b0[i], {8'd159, 7'd100, 3'b110});
      chk("rst_b1", i, b1[i], {8'd79, 7'd60, 3'b101});
      chk("rst_flags", i, 18'({go[i], fd[i], hl[i], ov[i]}), 18'd0);
    end
  endtask

  // Tick in IDLE, check N+1 and N+2 literally; returns in cycle N+2
  task automatic first_frame_checks();
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    chk("n1_go", 0, 18'(go[0]), 18'd0);
    chk("n1_x0", 0, 18'(b0[0][17:10]), 18'd159);
    cycle();
    chk("n2_go", 0, 18'(go[0]), 18'd1);
    chk("n2_x0", 0, 18'(b0[0][17:10]), 18'd158);
    chk("n2_x1", 0, 18'(b1[0][17:10]), 18'd78);
    chk("n2_x0", 1, 18'(b0[1][17:10]), 18'd155);
    chk("n2_x1", 1, 18'(b1[1][17:10]), 18'd75);
  endtask

  initial begin
    int halt_cycles;
    cycle();
    cycle();
    resetn = 1'b1;
    check_reset_values();

    // Scenario 1: single frame, cd_done at N+5
    first_frame_checks();
    cycle();
    chk("n3_go", 0, 18'(go[0]), 18'd0);
    cycle();
    cycle();
    cd_done = 1'b1;
    cycle();
    cd_done = 1'b0;
    chk("n6_frame_done", 0, 18'(fd[0]), 18'd1);
    cycle();
    chk("n7_frame_done", 0, 18'(fd[0]), 18'd0);

    // Tick while waiting for the checker is dropped and sets overrun
    frame_tick = 1'b1; cycle(); frame_tick = 1'b0;
    cycle(); cycle();
    frame_tick = 1'b1; cycle(); frame_tick = 1'b0;
    chk("overrun_set", 0, 18'(ov[0]), 18'd1);
    chk("overrun_no_go", 0, 18'(go[0]), 18'd0);
    cycle();
    cd_done = 1'b1; cycle(); cd_done = 1'b0;
    cycle();
    chk("overrun_sticky", 0, 18'(ov[0]), 18'd1);

    // gg together with cd_done: HALT wins, playfield frozen afterwards
    frame_tick = 1'b1; cycle(); frame_tick = 1'b0;
    cycle(); cycle();
    gg = 1'b1; cd_done = 1'b1;
    cycle();
    gg = 1'b0; cd_done = 1'b0;
    chk("gg_halted", 0, 18'(hl[0]), 18'd1);
    chk("gg_no_done", 0, 18'(fd[0]), 18'd0);
    for (int k = 0; k < 12; k++) begin
      frame_tick = k[0];
      cycle();
      chk("halt_go", 0, 18'(go[0]), 18'd0);
      chk("halt_x0", 0, 18'(b0[0][17:10]), 18'd156);
      chk("halt_x0", 1, 18'(b0[1][17:10]), 18'd147);
    end
    frame_tick = 1'b0;

    // Reset from HALT, then reset in the middle of a pending check
    resetn = 1'b0; cycle(); resetn = 1'b1;
    check_reset_values();
    first_frame_checks();
    cycle();
    resetn = 1'b0; cycle(); resetn = 1'b1;
    check_reset_values();
    first_frame_checks();

    // Randomised traffic
    halt_cycles = 0;
    for (int n = 0; n < 24000; n++) begin
      frame_tick = ($urandom_range(0, 3) == 0);
      cd_done    = ($urandom_range(0, 2) == 0);
      gg         = ($urandom_range(0, 4999) == 0);
      halt_cycles = mhalt[0] ? halt_cycles + 1 : 0;
      resetn     = !(($urandom_range(0, 7999) == 0) || halt_cycles > 20);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/boulder_scroller.md
# boulder_scroller

Frame-level obstacle sequencer for the side-scroller. Once per frame tick it moves the two boulder sprites left and respawns any boulder that reaches the left edge. It then starts the collision checker with a one-cycle `go`, waits for its `cd_done`, and freezes the playfield permanently once game-over (`gg`) is reported. It is the initiator side of the `go`/`cd_done` handshake and the sole source of `boulder_0`/`boulder_1`.

## Interface
Position word format (all 18-bit ports): [17:10] x (0..159), [9:3] y (0..119), [2:0] colour. The collision checker compares bits [17:3].

Parameters:
- X_START, 159 — x used at respawn.
- SPEED, 1 — pixels moved per frame (1..15).
- B1_OFFSET, 80 — boulder_1 starts B1_OFFSET pixels left of X_START.
- Y_LANE0, 100 — boulder_0 y at reset (and at respawn when LFSR disabled).
- Y_LANE1, 60 — boulder_1 y, same rules.
- COLOUR0, 3'b110 / COLOUR1, 3'b101 — fixed colour fields.

Ports:
- clock  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per display frame
- cd_done  in  1  collision check complete (one-cycle pulse)
- gg  in  1  game over from collision checker (level)
- boulder_0  out  18  boulder 0 position word
- boulder_1  out  18  boulder 1 position word
- go  out  1  one-cycle start pulse to collision checker
- frame_done  out  1  one-cycle pulse, frame update and check finished
- halted  out  1  high from HALT entry until reset
- overrun  out  1  sticky: a frame_tick arrived outside IDLE

## Operation
- Reset values:
  - boulder_0 = {X_START, Y_LANE0, COLOUR0}.
  - boulder_1 = {X_START−B1_OFFSET, Y_LANE1, COLOUR1}.
  - go = frame_done = halted = overrun = 0; state IDLE; LFSR = 8'hA5.
- States:
  - IDLE: go to MOVE on frame_tick, else stay.
  - MOVE: positions updated; always to LAUNCH.
  - LAUNCH: go=1; always to WAIT_CD.
  - WAIT_CD: go to DONE on cd_done, else stay. No timeout.
  - DONE: frame_done=1; always to IDLE.
  - HALT: terminal until reset; halted=1.
- gg priority: gg=1 in any state forces next state HALT, overriding all other transitions including cd_done. In HALT, positions, LFSR and overrun are frozen and go = frame_done = 0.
- Move rule, each boulder independent:
  - if x ≥ SPEED, x ← x − SPEED with y and colour unchanged;
  - else respawn: x ← X_START, new y. Colour is never altered.
- Both boulders may respawn in the same MOVE cycle.
- overrun is set when frame_tick=1 in any state other than IDLE or HALT. That tick is dropped (no queueing). overrun is cleared only by reset.
- Arithmetic is 8-bit unsigned. The x ≥ SPEED check guarantees no underflow.

## Timing
- frame_tick high at cycle N (state IDLE):
  - MOVE at N+1; new positions visible from N+2;
  - go high exactly during N+2 only; WAIT_CD from N+3.
- cd_done high at cycle M (state WAIT_CD): frame_done high at M+1, IDLE at M+2. A frame_tick at M+2 is accepted.
- go is registered and never high for more than one consecutive cycle.
- Positions are stable from N+2 until the next MOVE, so they do not change while the checker compares them.
- resetn low in any cycle, including mid-WAIT_CD or in HALT: all reset values hold at the next edge. A pending check is abandoned and cd_done is not awaited.

## Configuration
- BOULDER_LFSR_EN defined:
  - 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, advances every cycle except in HALT.
  - Respawn y for boulder_0 = r0 = lfsr[6:0]; for boulder_1 = r1 = ~lfsr[6:0].
  - Each value is clamped: if r ≥ 120, y = r − 8.
- BOULDER_LFSR_EN undefined: no LFSR. Respawn y is always Y_LANE0 / Y_LANE1.

## Test plan
- Reset then a single frame_tick with SPEED=1 → boulder_0 x 159→158 and boulder_1 x 79→78 visible at N+2; go pulses only at N+2; cd_done at N+5 → frame_done at N+6.
- Drive boulder_1 to x=0, then frame_tick → boulder_1 x=159. With the macro undefined, y=60 and colour 3'b101. With the macro defined, y<120.
- SPEED=4, boulder_0 x=3 → respawn at 159, not wrap to 255.
- frame_tick while in WAIT_CD → no extra go, overrun=1, and overrun stays 1 after later frames.
- gg=1 together with cd_done in WAIT_CD → HALT; frame_done stays 0; halted=1; further frame_ticks cause no position change and no go.
- resetn low during WAIT_CD → all outputs at reset values next cycle; the first frame_tick afterwards behaves as in the first scenario.
